// File: rtl/lsu_dmem_port.sv
// RV32I load/store unit driving a synchronous word-wide DMEM with byte strobes.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsu_dmem_port #(
    parameter int MEM_LATENCY = 1,
    parameter int DMEM_WORDS  = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [2:0]                    req_funct3,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    input  logic [4:0]                    req_rd,
    output logic                          mem_en,
    output logic [3:0]                    mem_we,
    output logic [$clog2(DMEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata,
    output logic                          rsp_valid,
    output logic [4:0]                    rsp_rd,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_err
);

    localparam int AW = $clog2(DMEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            rq_we_q, rq_we_d;
    logic [2:0]      rq_f3_q, rq_f3_d;
    logic [1:0]      rq_off_q, rq_off_d;
    logic [4:0]      rq_rd_q, rq_rd_d;
    logic            mem_en_q, mem_en_d;
    logic [3:0]      mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [4:0]      rsp_rd_q, rsp_rd_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic            accept;
    logic            f3_legal;
    logic            req_err;
    logic [1:0]      off;
    logic [1:0]      off_eff;
    logic [3:0]      st_we;
    logic [31:0]     st_wdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            misaligned;
`endif
    logic            unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    assign req_ready = reset_n && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        off = req_addr[1:0];
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !req_we;
            default:                f3_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        unique case (req_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_err = !f3_legal || misaligned;
        off_eff = off;
`else
        req_err = !f3_legal;
        unique case (req_funct3[1:0])
            2'b01:   off_eff = {off[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off;
        endcase
`endif
        unique case (req_funct3[1:0])
            2'b00: begin
                st_we    = 4'b0001 << off_eff;
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_we    = 4'b0011 << off_eff;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_we    = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    // Lane select uses the offset latched at acceptance, already aligned if needed.
    always_comb begin
        ld_byte = mem_rdata[{rq_off_q, 3'b000} +: 8];
        ld_half = rq_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (rq_f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rq_we_d     = rq_we_q;
        rq_f3_d     = rq_f3_q;
        rq_off_d    = rq_off_q;
        rq_rd_d     = rq_rd_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = '0;
        mem_wdata_d = 32'h0;
        rsp_valid_d = 1'b0;
        rsp_rd_d    = 5'd0;
        rsp_data_d  = 32'h0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rq_we_d  = req_we;
                    rq_f3_d  = req_funct3;
                    rq_off_d = off_eff;
                    rq_rd_d  = req_rd;
                    if (req_err) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rd_d    = req_we ? 5'd0 : req_rd;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_en_d    = 1'b1;
                        mem_addr_d  = req_addr[2 +: AW];
                        mem_we_d    = req_we ? st_we : 4'b0000;
                        mem_wdata_d = req_we ? st_wdata : 32'h0;
                    end
                end
            end
            S_ACCESS: begin
                if (rq_we_q) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 2'(MEM_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = rq_rd_q;
                    rsp_data_d  = ld_data;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            rq_we_q     <= 1'b0;
            rq_f3_q     <= 3'd0;
            rq_off_q    <= 2'd0;
            rq_rd_q     <= 5'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 5'd0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rq_we_q     <= rq_we_d;
            rq_f3_q     <= rq_f3_d;
            rq_off_q    <= rq_off_d;
            rq_rd_q     <= rq_rd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Randomized bench for lsu_dmem_port against a byte-addressed memory model.
// Honors LSU_MISALIGN_TRAP_EN when computing expectations.
`timescale 1ns/1ps
module tb_lsu_dmem_port;

    localparam int LAT   = 3;
    localparam int WORDS = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [4:0]    req_rd;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          rsp_valid;
    logic [4:0]    rsp_rd;
    logic [31:0]   rsp_data;
    logic          rsp_err;

    lsu_dmem_port #(
        .MEM_LATENCY(LAT),
        .DMEM_WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rd    (rsp_rd),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Synchronous DMEM fixture with a LAT-deep read pipeline
    logic        tb_init;
    logic [31:0] dmem  [WORDS];
    logic [31:0] rpipe [LAT];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < WORDS; i++) dmem[i] <= 32'h0;
            for (int i = 0; i < LAT; i++) rpipe[i] <= 32'h0;
        end else begin
            if (mem_en)
                for (int i = 0; i < 4; i++)
                    if (mem_we[i]) dmem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            rpipe[0] <= mem_en ? dmem[mem_addr] : 32'h0;
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
    end
    assign mem_rdata = rpipe[LAT-1];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  refmem [4096];
    logic [31:0] last_data;
    logic        last_err;
    logic [4:0]  last_rd;
    logic [AW-1:0] last_maddr;
    logic [3:0]  last_mwe;
    logic [31:0] last_mwdata;
    int          seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        @(negedge clk);
        for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
        check("ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd);
        int size, idx, elat, lat, en_cnt, en_cyc;
        logic legal, mis, err, rdy_busy;
        logic [31:0] ba, ed, ewd;
        logic [3:0] ewe;
        logic [4:0] erd;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (addr & 32'(size - 1)) != 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        err = !legal || mis;
`else
        err = !legal;
`endif
        ba  = addr & ~32'(size - 1);
        ed  = 32'h0;
        ewd = 32'h0;
        ewe = 4'h0;
        erd = we ? 5'd0 : rd;
        if (err) begin
            elat = 1;
        end else if (we) begin
            elat = 2;
            for (int k = 0; k < size; k++) begin
                idx = int'((ba + 32'(k)) & 32'hFFF);
                refmem[idx] = wd[8*k +: 8];
                ewe[idx & 3] = 1'b1;
            end
            ewd = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
        end else begin
            elat = LAT + 2;
            for (int k = 0; k < size; k++) begin
                idx = int'((ba + 32'(k)) & 32'hFFF);
                ed[8*k +: 8] = refmem[idx];
            end
            if (!f3[2] && size < 4 && ed[8*size-1])
                for (int k = size; k < 4; k++) ed[8*k +: 8] = 8'hFF;
        end

        wait_ready();
        drive(we, f3, addr, wd, rd);
        lat = 0; en_cnt = 0; en_cyc = 0; rdy_busy = 1'b0;
        last_data = 32'h0; last_err = 1'b0; last_rd = 5'd0;
        last_maddr = '0; last_mwe = 4'h0; last_mwdata = 32'h0;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(negedge clk);
            if (req_ready) rdy_busy = 1'b1;
            if (mem_en) begin
                en_cnt++;
                en_cyc      = c;
                last_maddr  = mem_addr;
                last_mwe    = mem_we;
                last_mwdata = mem_wdata;
            end
            if (rsp_valid) begin
                lat       = c;
                last_data = rsp_data;
                last_err  = rsp_err;
                last_rd   = rsp_rd;
                break;
            end
        end
        check("latency", 32'(lat), 32'(elat));
        check("rsp_err", 32'(last_err), 32'(err));
        check("rsp_rd", 32'(last_rd), 32'(erd));
        check("rsp_data", last_data, ed);
        check("mem_en_count", 32'(en_cnt), err ? 32'd0 : 32'd1);
        check("busy_ready", 32'(rdy_busy), 32'd0);
        if (!err) begin
            check("mem_en_cycle", 32'(en_cyc), 32'd1);
            check("mem_addr", 32'(last_maddr), (addr >> 2) & 32'(WORDS - 1));
            check("mem_we", 32'(last_mwe), 32'(ewe));
            if (we) check("mem_wdata", last_mwdata, ewd);
        end
        @(negedge clk);
        check("post_resp", 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        tb_init    = 1'b1;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        for (int i = 0; i < 4096; i++) refmem[i] = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        tb_init = 1'b0;
        check("rst_outs", 32'({mem_en, mem_we, rsp_valid, rsp_err}), 32'h0);
        check("rst_data", rsp_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd3);
        check("tp_sw_addr", 32'(last_maddr), 32'd4);
        check("tp_sw_we", 32'(last_mwe), 32'hF);
        check("tp_sw_wdata", last_mwdata, 32'hDEADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd5);
        check("tp_lb", last_data, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd6);
        check("tp_lbu", last_data, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 5'd7);
        check("tp_lh", last_data, 32'hFFFFBEEF);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 5'd8);
        check("tp_lhu", last_data, 32'h0000DEAD);
        do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, 5'd1);
        check("tp_sb_we", 32'(last_mwe), 32'b0010);
        check("tp_sb_wdata", last_mwdata, 32'hAAAAAAAA);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd2);
        check("tp_lw_merge", last_data, 32'hDEADAAEF);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        check("tp_mis_err", 32'(last_err), 32'd1);
`else
        check("tp_mis_addr", 32'(last_maddr), 32'd3);
        check("tp_mis_err", 32'(last_err), 32'd0);
`endif
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 5'd9);
        check("tp_ill_err", 32'(last_err), 32'd1);
        check("tp_ill_rd", 32'(last_rd), 32'd9);
        do_req(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 5'd0);
        check("tp_wrap_addr", 32'(last_maddr), 32'd0);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 5'd10);
        check("tp_wrap_read", last_data, 32'hCAFEF00D);

        // reset during WAIT of a load
        wait_ready();
        drive(1'b0, 3'b010, 32'h10, 32'h0, 5'd11);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_abort_outs", 32'({mem_en, rsp_valid, req_ready}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        @(negedge clk);
        check("rst_abort_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        check("rst_abort_no_rsp", 32'(seen), 32'd0);

        // reset during ACCESS of a store: the write must not land
        wait_ready();
        drive(1'b1, 3'b010, 32'h20, 32'h12345678, 5'd0);
        @(negedge clk);
        check("st_abort_en", 32'(mem_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("st_abort_en_off", 32'(mem_en), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5'd12);
        check("st_abort_nowrite", last_data, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd13);

        for (int n = 0; n < 300; n++) begin
            rwe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                rf3 = 3'($urandom_range(0, 7));
            else if (rwe)
                rf3 = 3'($urandom_range(0, 2));
            else
                rf3 = 3'($urandom_range(0, 4)) + (($urandom_range(0, 4) > 2) ? 3'd1 : 3'd0);
            raddr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) raddr = raddr | ($urandom & 32'hFFFF_F000);
            do_req(rwe, rf3, raddr, $urandom, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
